// File: rtl/rx_serial_pkg.sv
// Shared definitions for the 7O1 serial receiver: FSM state codes, frame width
// and the odd-parity helper.
package rx_serial_pkg;

    localparam int DATA_BITS = 7;

    // Codes are visible on db_estado, so they stay fixed.
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        START  = 4'd1,
        DATA   = 4'd2,
        PARITY = 4'd3,
        STOP   = 4'd4,
        DONE   = 4'd5,
        BREAK  = 4'd6
    } estado_t;

    // 1 when data bits plus parity bit hold an odd number of ones.
    function automatic logic paridade_impar(input logic [DATA_BITS-1:0] dados,
                                            input logic                 bit_par);
        return ^{dados, bit_par};
    endfunction

endpackage

// File: rtl/rx_serial_7o1_uc.sv
// Control FSM of the 7O1 receiver: sequences start/data/parity/stop sampling
// and issues one-cycle strobes to the datapath in the top level.
module rx_serial_7O1_uc
    import rx_serial_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_s,
    input  logic       meio_bit,
    input  logic       fim_bit,
    input  logic       ultimo_bit,
    output logic       zera,
    output logic       conta,
    output logic       reinicia,
    output logic       desloca,
    output logic       amostra_par,
    output logic       carrega,
    output logic       registra_erro,
    output logic [3:0] db_estado
);

    estado_t estado;

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado <= IDLE;
        end else begin
            case (estado)
                IDLE:    if (!rx_s) estado <= START;
                START:   if (meio_bit) estado <= rx_s ? IDLE : DATA;
                DATA:    if (fim_bit && ultimo_bit) estado <= PARITY;
                PARITY:  if (fim_bit) estado <= STOP;
                STOP:    if (fim_bit) estado <= rx_s ? DONE : BREAK;
                DONE:    estado <= IDLE;
                BREAK:   if (rx_s) estado <= IDLE;
                default: estado <= IDLE;
            endcase
        end
    end

    // Every sample point also wraps the baud counter, so samples stay one bit apart.
    always_comb begin
        zera          = 1'b0;
        conta         = 1'b0;
        reinicia      = 1'b0;
        desloca       = 1'b0;
        amostra_par   = 1'b0;
        carrega       = 1'b0;
        registra_erro = 1'b0;
        case (estado)
            IDLE: begin
                if (!rx_s) zera = 1'b1;
            end
            START: begin
                if (meio_bit) begin
                    reinicia = 1'b1;
                    if (!rx_s) zera = 1'b1;
                end else begin
                    conta = 1'b1;
                end
            end
            DATA: begin
                if (fim_bit) begin
                    reinicia = 1'b1;
                    desloca  = 1'b1;
                end else begin
                    conta = 1'b1;
                end
            end
            PARITY: begin
                if (fim_bit) begin
                    reinicia    = 1'b1;
                    amostra_par = 1'b1;
                end else begin
                    conta = 1'b1;
                end
            end
            STOP: begin
                if (fim_bit) begin
                    reinicia = 1'b1;
                    if (!rx_s) registra_erro = 1'b1;
                end else begin
                    conta = 1'b1;
                end
            end
            DONE: begin
                carrega = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign db_estado = estado;

endmodule

// File: rtl/rx_serial_7o1.sv
// 7O1 UART receiver top: input synchronizer, baud/bit counters, shift register
// and output registers. Define RX_PARITY_DROP_EN to discard bad-parity frames.
module rx_serial_7o1
    import rx_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 dado_serial,
    input  logic                 limpa,
    output logic [DATA_BITS-1:0] dados_ascii,
    output logic                 paridade_ok,
    output logic                 pronto,
    output logic                 tem_dado,
    output logic                 erro_stop,
    output logic [3:0]           db_estado
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam int BW       = $clog2(DATA_BITS + 1);

    logic                 rx_m;
    logic                 rx_s;
    logic [CW-1:0]        baud_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 bit_par;

    logic meio_bit;
    logic fim_bit;
    logic ultimo_bit;
    logic par_calc;

    logic zera;
    logic conta;
    logic reinicia;
    logic desloca;
    logic amostra_par;
    logic carrega;
    logic registra_erro;

    assign meio_bit   = (baud_cnt == CW'(HALF_BIT - 1));
    assign fim_bit    = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    assign ultimo_bit = (bit_cnt == BW'(DATA_BITS - 1));
    assign par_calc   = paridade_impar(shift_reg, bit_par);

    rx_serial_7O1_uc u_uc (
        .clock         (clock),
        .reset         (reset),
        .rx_s          (rx_s),
        .meio_bit      (meio_bit),
        .fim_bit       (fim_bit),
        .ultimo_bit    (ultimo_bit),
        .zera          (zera),
        .conta         (conta),
        .reinicia      (reinicia),
        .desloca       (desloca),
        .amostra_par   (amostra_par),
        .carrega       (carrega),
        .registra_erro (registra_erro),
        .db_estado     (db_estado)
    );

    // Handshake: pronto pulses for one cycle with dados_ascii/paridade_ok valid;
    // tem_dado stays high until the consumer pulses limpa (a new frame beats limpa).
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            bit_par     <= 1'b0;
            dados_ascii <= '0;
            paridade_ok <= 1'b0;
            pronto      <= 1'b0;
            tem_dado    <= 1'b0;
            erro_stop   <= 1'b0;
        end else begin
            rx_m <= dado_serial;
            rx_s <= rx_m;

            if (zera || reinicia) begin
                baud_cnt <= '0;
            end else if (conta) begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            if (zera) begin
                bit_cnt <= '0;
            end else if (desloca) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            // LSB arrives first, so after the last shift it sits in bit 0.
            if (desloca) shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            if (amostra_par) bit_par <= rx_s;

            pronto <= 1'b0;
            if (limpa) begin
                tem_dado  <= 1'b0;
                erro_stop <= 1'b0;
            end
            if (registra_erro) erro_stop <= 1'b1;

            if (carrega) begin
                erro_stop <= 1'b0;
`ifdef RX_PARITY_DROP_EN
                if (par_calc) begin
                    dados_ascii <= shift_reg;
                    paridade_ok <= 1'b1;
                    pronto      <= 1'b1;
                    tem_dado    <= 1'b1;
                end else begin
                    paridade_ok <= 1'b0;
                end
`else
                dados_ascii <= shift_reg;
                paridade_ok <= par_calc;
                pronto      <= 1'b1;
                tem_dado    <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_rx_serial_7o1.sv
// Bench for rx_serial_7o1: frame-level model predicting output events from the
// frames the drivers put on the line, checked against the DUT every cycle.
module tb_rx_serial_7o1;

  localparam int CPB      = 16;
  localparam int H        = CPB / 2;
  localparam int DONE_OFS = 3 + H + 9 * CPB;
  localparam int ERR_OFS  = 2 + H + 9 * CPB;

  logic       clock = 1'b0;
  logic       reset;
  logic       dado_serial;
  logic       limpa;
  logic [6:0] dados_ascii;
  logic       paridade_ok;
  logic       pronto;
  logic       tem_dado;
  logic       erro_stop;
  logic [3:0] db_estado;

  rx_serial_7o1 #(.CLKS_PER_BIT(CPB)) dut (
    .clock       (clock),
    .reset       (reset),
    .dado_serial (dado_serial),
    .limpa       (limpa),
    .dados_ascii (dados_ascii),
    .paridade_ok (paridade_ok),
    .pronto      (pronto),
    .tem_dado    (tem_dado),
    .erro_stop   (erro_stop),
    .db_estado   (db_estado)
  );

  initial forever #5 clock = ~clock;

  typedef struct {
    int         at_edge;
    bit         is_done;
    logic [6:0] d;
    logic       p;
  } ev_t;

  ev_t        exp_q[$];
  int         edge_n = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         pronto_cnt = 0;
  bit         rand_limpa_en = 1'b0;
  logic [6:0] m_data;
  logic       m_ok;
  logic       m_pronto;
  logic       m_tem;
  logic       m_err;

  function automatic logic odd_ok(input logic [6:0] d, input logic p);
    return ($countones({d, p}) % 2) == 1;
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    limpa = rand_limpa_en && ($urandom_range(0, 15) == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      dado_serial = 1'b1;
    end
  endtask

  task automatic chk_all_zero();
    chk("rst_dados", dados_ascii, 7'h00);
    chk("rst_par", 7'(paridade_ok), 7'h0);
    chk("rst_pronto", 7'(pronto), 7'h0);
    chk("rst_tem", 7'(tem_dado), 7'h0);
    chk("rst_err", 7'(erro_stop), 7'h0);
    chk("rst_estado", 7'(db_estado), 7'h0);
  endtask

  // rst_bit >= 0 pulses reset in the middle of that bit and abandons the frame.
  task automatic send_frame(input logic [6:0] d, input logic p, input logic stp,
                            input int hold_low, input int rst_bit);
    logic [9:0] bits;
    ev_t        ev;
    int         e0;
    bits = {stp, p, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < CPB; i++) begin
        tick();
        if (b == 0 && i == 0) begin
          e0 = edge_n + 1;
          if (rst_bit < 0) begin
            ev.at_edge = stp ? e0 + DONE_OFS : e0 + ERR_OFS;
            ev.is_done = stp;
            ev.d       = d;
            ev.p       = p;
            exp_q.push_back(ev);
          end
        end
        dado_serial = bits[b];
        if (b == rst_bit && i == H) begin
          reset = 1'b0;
          tick();
          reset = 1'b1;
          dado_serial = 1'b1;
          chk_all_zero();
          return;
        end
      end
    end
    if (!stp) begin
      for (int i = 0; i < hold_low; i++) begin
        tick();
        dado_serial = 1'b0;
      end
      chk("break_state", 7'(db_estado), 7'd6);
    end
    tick();
    dado_serial = 1'b1;
  endtask

  task automatic glitch(input int n_low);
    int c;
    c = 0;
    for (int k = 0; k < H + 6; k++) begin
      tick();
      if (k == 0) c = edge_n;
      dado_serial = (k < n_low) ? 1'b0 : 1'b1;
      if (edge_n == c + 3) chk("glitch_start", 7'(db_estado), 7'd1);
      if (edge_n == c + 3 + H) chk("glitch_idle", 7'(db_estado), 7'd0);
    end
  endtask

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    reset = 1'b0;
    dado_serial = 1'b1;
    limpa = 1'b0;

    fork
      forever begin
        ev_t ev;
        logic ok;
        @(posedge clock);
        edge_n++;
        if (!reset) begin
          m_data = '0; m_ok = 1'b0; m_pronto = 1'b0; m_tem = 1'b0; m_err = 1'b0;
          exp_q.delete();
        end else begin
          m_pronto = 1'b0;
          if (limpa) begin
            m_tem = 1'b0;
            m_err = 1'b0;
          end
          if (exp_q.size() > 0 && exp_q[0].at_edge == edge_n) begin
            ev = exp_q.pop_front();
            if (ev.is_done) begin
              ok = odd_ok(ev.d, ev.p);
              m_err = 1'b0;
`ifdef RX_PARITY_DROP_EN
              if (ok) begin
                m_data = ev.d; m_ok = 1'b1; m_pronto = 1'b1; m_tem = 1'b1;
              end else begin
                m_ok = 1'b0;
              end
`else
              m_data = ev.d; m_ok = ok; m_pronto = 1'b1; m_tem = 1'b1;
`endif
            end else begin
              m_err = 1'b1;
            end
          end
        end
      end
      forever begin
        @(negedge clock);
        if (edge_n > 0) begin
          chk("dados_ascii", dados_ascii, m_data);
          chk("paridade_ok", 7'(paridade_ok), 7'(m_ok));
          chk("pronto", 7'(pronto), 7'(m_pronto));
          chk("tem_dado", 7'(tem_dado), 7'(m_tem));
          chk("erro_stop", 7'(erro_stop), 7'(m_err));
          if (pronto === 1'b1) pronto_cnt++;
        end
      end
    join_none

    repeat (3) tick();
    chk_all_zero();
    reset = 1'b1;
    idle(5);

    // 0x41 with good odd parity
    p0 = pronto_cnt;
    send_frame(7'h41, 1'b1, 1'b1, 0, -1);
    idle(4);
    chk("f41_dados", dados_ascii, 7'h41);
    chk("f41_par", 7'(paridade_ok), 7'h1);
    chk("f41_tem", 7'(tem_dado), 7'h1);
    chk("f41_err", 7'(erro_stop), 7'h0);
    chk("f41_npronto", 7'(pronto_cnt - p0), 7'd1);

    tick();
    limpa = 1'b1;
    tick();
    chk("limpa_tem", 7'(tem_dado), 7'h0);
    chk("limpa_dados", dados_ascii, 7'h41);

    // 0x41 with bad parity
    p0 = pronto_cnt;
    send_frame(7'h41, 1'b0, 1'b1, 0, -1);
    idle(4);
`ifdef RX_PARITY_DROP_EN
    chk("bad_npronto", 7'(pronto_cnt - p0), 7'd0);
    chk("bad_tem", 7'(tem_dado), 7'h0);
    chk("bad_par", 7'(paridade_ok), 7'h0);
`else
    chk("bad_npronto", 7'(pronto_cnt - p0), 7'd1);
    chk("bad_dados", dados_ascii, 7'h41);
    chk("bad_par", 7'(paridade_ok), 7'h0);
`endif

    // short low pulse on an idle line
    p0 = pronto_cnt;
    glitch(4);
    chk("glitch_npronto", 7'(pronto_cnt - p0), 7'd0);

    // stop bit low, line held low, then release
    p0 = pronto_cnt;
    send_frame(7'h2a, 1'b0, 1'b0, 40, -1);
    idle(6);
    chk("brk_err", 7'(erro_stop), 7'h1);
    chk("brk_npronto", 7'(pronto_cnt - p0), 7'd0);
    chk("brk_estado", 7'(db_estado), 7'd0);
    send_frame(7'h7f, 1'b0, 1'b1, 0, -1);
    idle(4);
    chk("f7f_dados", dados_ascii, 7'h7f);
    chk("f7f_par", 7'(paridade_ok), 7'h1);
    chk("f7f_err", 7'(erro_stop), 7'h0);

    // reset during data bit 3, then a clean frame
    send_frame(7'h33, 1'b1, 1'b1, 0, 4);
    idle(4);
    send_frame(7'h55, 1'b1, 1'b1, 0, -1);
    idle(4);
    chk("f55_dados", dados_ascii, 7'h55);
    chk("f55_par", 7'(paridade_ok), 7'h1);
    chk("f55_tem", 7'(tem_dado), 7'h1);
    tick();
    limpa = 1'b1;
    tick();
    chk("f55_limpa_tem", 7'(tem_dado), 7'h0);
    chk("f55_limpa_dados", dados_ascii, 7'h55);

    // randomized traffic with random consumer acknowledges
    rand_limpa_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r == 0) begin
        glitch($urandom_range(1, H));
      end else if (r == 1) begin
        send_frame(7'($urandom), 1'($urandom), 1'b1, 0, $urandom_range(1, 8));
      end else begin
        send_frame(7'($urandom), 1'($urandom), (r != 2), $urandom_range(0, 20), -1);
      end
      idle($urandom_range(2, 12));
    end
    rand_limpa_en = 1'b0;
    idle(10);
    chk("queue_drained", 7'(exp_q.size()), 7'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_serial_7o1.md
Name: rx_serial_7O1

Overview:
- UART receiver for 7O1 frames: start bit, 7 data bits LSB first, odd parity bit, 1 stop bit.
- Sits directly downstream of the serial transmitter and consumes its line output, either by loopback or across the board link.
- Recovers bit timing from a free-running baud counter and samples each bit at mid-bit.
- Delivers the received ASCII character, a parity flag and a data-valid handshake to the application logic.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); must be even and >= 8.
- HALF_BIT, CLKS_PER_BIT/2, offset from the start-bit edge to its mid-bit sample (derived; do not override).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (reset=0 clears the block at the next rising edge).
- dado_serial  in  1  serial line; idle high; asynchronous to clock.
- limpa  in  1  consumer acknowledge; clears tem_dado.
- dados_ascii  out  7  last received character.
- paridade_ok  out  1  1 when the last frame had odd total parity over data plus parity bit.
- pronto  out  1  one-cycle pulse when a frame is accepted.
- tem_dado  out  1  level; set on accept, held until limpa.
- erro_stop  out  1  sticky framing-error flag; cleared by limpa or by the next accepted frame.
- db_estado  out  4  current FSM state code, for debug and 7-segment display.

Behaviour:
- Reset (reset=0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0; db_estado shows the IDLE code.
  - Baud counter, bit counter and shift register go to 0.
  - Synchronizer flops are preset to 1.
  - Reset takes effect mid-frame with no partial output.
- Input path:
  - Two-flop synchronizer on dado_serial; the FSM sees only the synchronized signal rx_s.
  - Input-to-FSM latency is 2 cycles.
- FSM states and transitions:
  - IDLE (0): when rx_s=0, clear the baud counter and go to START.
  - START (1): count to HALF_BIT-1. If rx_s=0 at that point, clear the baud counter and bit counter and go to DATA. Otherwise it was a glitch; go to IDLE.
  - DATA (2): count to CLKS_PER_BIT-1, then shift rx_s into the MSB of a 7-bit right-shift register and increment the bit counter. After the 7th bit, go to PARITY.
  - PARITY (3): sample at CLKS_PER_BIT-1 into the parity register, then go to STOP.
  - STOP (4): sample at CLKS_PER_BIT-1. If rx_s=1, go to DONE. If rx_s=0, set erro_stop=1 and go to BREAK.
  - DONE (5), one cycle:
    - load dados_ascii from the shift register;
    - paridade_ok = XOR of the 7 data bits and the parity bit;
    - pronto=1, tem_dado=1, erro_stop=0;
    - go to IDLE.
  - BREAK (6): wait for rx_s=1, then go to IDLE. No pronto is generated.
- Counter rule: the baud counter wraps to 0 on every mid-bit sample. The sample points are HALF_BIT + k*CLKS_PER_BIT cycles after the synchronized falling edge.
- Latency: pronto rises 1 cycle after the stop-bit sample, about 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles after the line's falling edge.
- Output persistence: dados_ascii and paridade_ok hold their values until the next DONE. limpa does not clear them.
- Simultaneous limpa and DONE: DONE wins; tem_dado stays 1.
- Overrun: a new frame completing while tem_dado=1 overwrites dados_ascii. There is no overrun flag.
- Line held low continuously: at most one erro_stop is raised; the block stays in BREAK.

Optional Feature:
- Macro RX_PARITY_DROP_EN.
- When defined, a frame with bad parity in DONE does not assert pronto or tem_dado. dados_ascii is not updated, and paridade_ok is set to 0.
- When undefined, every frame with a valid stop bit is delivered and paridade_ok reports its parity.

Decomposition:
- Package rx_serial_pkg holds:
  - state encoding localparams IDLE..BREAK (4-bit codes 0-6);
  - DATA_BITS=7;
  - the odd-parity helper function.
- One natural sub-module, rx_serial_7O1_uc: the FSM, producing control strobes (zera, conta, desloca, carrega, registra_erro).
- The top level holds the datapath: synchronizer, baud and bit counters, shift register, output registers.

Test Plan:
- CLKS_PER_BIT=16. Send 0x41 with parity bit 1 and stop bit 1 → dados_ascii=0x41, paridade_ok=1, a single-cycle pronto, tem_dado=1, erro_stop=0.
- Send 0x41 with parity bit 0 → without the macro: pronto, dados_ascii=0x41, paridade_ok=0. With RX_PARITY_DROP_EN: no pronto, tem_dado=0.
- Drive the line low for 4 cycles, then high → no pronto; db_estado returns to 0 within HALF_BIT+3 cycles.
- Send a frame with stop bit 0 and hold the line low for 40 cycles, then release → erro_stop=1, no pronto. A following frame 0x7F (parity 0) yields dados_ascii=0x7F, paridade_ok=1, erro_stop=0.
- Assert reset=0 for 1 cycle during data bit 3 → all outputs are 0 on the next cycle. A following frame 0x55 (parity 1) is received correctly.
- After a good reception, pulse limpa → tem_dado=0 on the next cycle; dados_ascii is still 0x55.
